// File: rtl/xram_arb_pkg.sv
// Shared types and constants for the XRAM port arbiter.
package xram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01
   } state_t;

   localparam int DEF_NUM_REQ  = 3;
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_MAX_HOLD = 16;

   localparam int REQ_MEMWR = 0;
   localparam int REQ_AES   = 1;
   localparam int REQ_SHA   = 2;

   localparam int HOLD_W = 8;

endpackage

// File: rtl/xram_arb_if.sv
// Requester-side and XRAM-side signals of the shared byte port.
interface xram_arb_if
   import xram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
);
   logic [NUM_REQ-1:0]        req_stb;
   logic [NUM_REQ-1:0]        req_wr;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data_out;
   logic [NUM_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]         req_data_in;
   logic [ADDR_W-1:0]         xram_addr;
   logic [DATA_W-1:0]         xram_data_out;
   logic [DATA_W-1:0]         xram_data_in;
   logic                      xram_ack;
   logic                      xram_stb;
   logic                      xram_wr;

   modport master (
      input  req_stb, req_wr, req_addr, req_data_out,
      input  xram_data_in, xram_ack,
      output req_ack, req_data_in,
      output xram_addr, xram_data_out, xram_stb, xram_wr
   );

   modport slave (
      output req_stb, req_wr, req_addr, req_data_out,
      output xram_data_in, xram_ack,
      input  req_ack, req_data_in,
      input  xram_addr, xram_data_out, xram_stb, xram_wr
   );

endinterface

// File: rtl/xram_arb_rr.sv
// Round-robin pick: first set request at or after ptr, returned one-hot.
module xram_arb_rr
   import xram_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [N-1:0]  pick
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] back;
   logic [N-1:0]   rot;
   logic [N-1:0]   first;

   always_comb begin
      dbl   = {req, req} >> ptr;
      rot   = dbl[N-1:0];
      first = rot & (-rot);
      back  = {first, first} << ptr;
      pick  = back[2*N-1:N];
      valid = |req;
   end

endmodule

// File: rtl/xram_arb.sv
// Round-robin owner of the XRAM byte port with a burst-hold limit.
module xram_arb
   import xram_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic               clk,
   input  logic               rst_n,
   xram_arb_if.master         bus,
   output logic [NUM_REQ-1:0] arb_grant,
   output logic               arb_busy,
   output logic [HOLD_W-1:0]  arb_hold_cnt
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   logic                rr_valid;
   logic [NUM_REQ-1:0]  rr_pick;
   logic [PW-1:0]       own_idx;
   logic [PW-1:0]       own_nxt;
   logic                own_stb;
   logic                others;
   logic [HOLD_W:0]     hold_inc;
   logic                at_lim;
   logic [HOLD_W-1:0]   hold_sat;

   xram_arb_rr #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .req   (bus.req_stb),
      .ptr   (ptr_q),
      .valid (rr_valid),
      .pick  (rr_pick)
   );

   always_comb begin
      own_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant_q[i]) own_idx = PW'(i);
   end

   always_comb begin
      own_nxt  = (own_idx == PW'(NUM_REQ - 1)) ? '0 : own_idx + PW'(1);
      own_stb  = bus.req_stb[own_idx];
      others   = |(bus.req_stb & ~grant_q);
      hold_inc = {1'b0, hold_q} + (HOLD_W+1)'(1);
      at_lim   = hold_inc >= (HOLD_W+1)'(MAX_HOLD);
      hold_sat = (&hold_q) ? hold_q : hold_inc[HOLD_W-1:0];
   end

   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      ptr_d             = ptr_q;
      hold_d            = hold_q;
      bus.xram_stb      = 1'b0;
      bus.xram_wr       = 1'b0;
      bus.xram_addr     = '0;
      bus.xram_data_out = '0;
      bus.req_ack       = '0;
      case (state_q)
         ST_IDLE: begin
            if (rr_valid) begin
               state_d = ST_GRANT;
               grant_d = rr_pick;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            bus.xram_stb      = own_stb;
            bus.xram_wr       = bus.req_wr[own_idx];
            bus.xram_addr     = bus.req_addr[own_idx*ADDR_W +: ADDR_W];
            bus.xram_data_out = bus.req_data_out[own_idx*DATA_W +: DATA_W];
            bus.req_ack       = grant_q & {NUM_REQ{bus.xram_ack}};
            if (!own_stb) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = own_nxt;
            end else if (bus.xram_ack) begin
               // preempt only on an acked boundary so no transfer is split
               if (at_lim && others) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  ptr_d   = own_nxt;
                  hold_d  = hold_sat;
               end else if (at_lim) begin
                  hold_d = '0;
               end else begin
                  hold_d = hold_sat;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.req_data_in = rst_n ? bus.xram_data_in : '0;
   assign arb_grant       = grant_q;
   assign arb_busy        = (state_q == ST_GRANT);
   assign arb_hold_cnt    = hold_q;

endmodule

// File: tb/tb_xram_arb.sv
// Randomized and directed bench for xram_arb against a behavioural owner model.
module tb_xram_arb;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int MH = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   xram_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   logic [N-1:0] arb_grant;
   logic         arb_busy;
   logic [7:0]   arb_hold_cnt;

   xram_arb #(
      .NUM_REQ  (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_HOLD (MH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .arb_grant    (arb_grant),
      .arb_busy     (arb_busy),
      .arb_hold_cnt (arb_hold_cnt)
   );

   int checks = 0;
   int errors = 0;

   int           rem [N];
   logic [N-1:0] ack_seen = '0;
   bit           rand_en  = 1'b0;
   bit           ack_rand = 1'b0;

   // model: owner index (-1 when idle), round-robin pointer, acks held
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;

   logic [N-1:0] s2_exp [12] = '{3'b001, 3'b001, 3'b001, 3'b000,
                                 3'b010, 3'b010, 3'b010, 3'b000,
                                 3'b100, 3'b100, 3'b100, 3'b000};
   int hold_exp [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_ptr   <= 0;
         m_cnt   <= 0;
      end else begin : upd
         automatic int o      = m_owner;
         automatic int p      = m_ptr;
         automatic int c      = m_cnt;
         automatic bit others = 1'b0;
         if (o < 0) begin
            for (int k = 0; k < N; k++)
               if (o < 0 && bus.req_stb[(m_ptr + k) % N]) o = (m_ptr + k) % N;
            c = 0;
         end else begin
            for (int j = 0; j < N; j++)
               if (j != o && bus.req_stb[j]) others = 1'b1;
            if (!bus.req_stb[o]) begin
               p = (o + 1) % N;
               o = -1;
            end else if (bus.xram_ack) begin
               if (c + 1 >= MH && others) begin
                  p = (o + 1) % N;
                  o = -1;
               end else if (c + 1 >= MH) begin
                  c = 0;
               end else begin
                  c = (c < 255) ? c + 1 : 255;
               end
            end
         end
         m_owner <= o;
         m_ptr   <= p;
         m_cnt   <= c;
      end
   end

   always @(negedge clk) begin : cmp
      automatic logic [N-1:0]  eg = '0;
      automatic logic [N-1:0]  ea = '0;
      automatic logic          es = 1'b0;
      automatic logic          ew = 1'b0;
      automatic logic [AW-1:0] ead = '0;
      automatic logic [DW-1:0] edo = '0;
      automatic logic [DW-1:0] edi = '0;
      if (rst_n) begin
         edi = bus.xram_data_in;
         if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ea[m_owner] = bus.xram_ack;
            es  = bus.req_stb[m_owner];
            ew  = bus.req_wr[m_owner];
            ead = bus.req_addr[m_owner*AW +: AW];
            edo = bus.req_data_out[m_owner*DW +: DW];
         end
      end
      chk("grant", arb_grant, eg);
      chk("busy", arb_busy, (rst_n && m_owner >= 0));
      chk("xram_stb", bus.xram_stb, es);
      chk("xram_wr", bus.xram_wr, ew);
      chk("xram_addr", bus.xram_addr, ead);
      chk("xram_data_out", bus.xram_data_out, edo);
      chk("req_ack", bus.req_ack, ea);
      chk("req_data_in", bus.req_data_in, edi);
      if (!rst_n) chk("hold_rst", arb_hold_cnt, 0);
      else if (m_owner >= 0) chk("hold_cnt", arb_hold_cnt, m_cnt);
      ack_seen <= bus.req_ack;
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (ack_seen[i] && rem[i] > 0) rem[i]--;
         if (rand_en && rem[i] == 0 && $urandom_range(7) == 0)
            rem[i] = $urandom_range(12, 1);
         bus.req_stb[i] = (rem[i] > 0);
         bus.req_wr[i]  = rand_en ? 1'($urandom_range(1)) : 1'b1;
         bus.req_addr[i*AW +: AW] =
            rand_en ? AW'($urandom) : AW'(16'h0100 * (i + 1));
         bus.req_data_out[i*DW +: DW] =
            rand_en ? DW'($urandom) : DW'(8'h10 + i);
      end
      bus.xram_ack     = ack_rand ? ($urandom_range(3) != 0) : 1'b1;
      bus.xram_data_in = DW'($urandom);
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) rem[i] = 0;
      step();
      step();
      at_neg();
      rst_n = 1'b1;
   endtask

   initial begin
      int a0;
      bit sw;
      rst_n            = 1'b0;
      bus.req_stb      = '0;
      bus.req_wr       = '0;
      bus.req_addr     = '0;
      bus.req_data_out = '0;
      bus.xram_ack     = 1'b0;
      bus.xram_data_in = '0;
      for (int i = 0; i < N; i++) rem[i] = 0;

      // reset holds every output low even with a strobe and ack present
      rem[0] = 5;
      step();
      step();
      at_neg();
      chk("rst_grant", arb_grant, 3'b000);
      chk("rst_busy", arb_busy, 1'b0);
      chk("rst_stb", bus.xram_stb, 1'b0);
      chk("rst_ack", bus.req_ack, 3'b000);
      rem[0] = 0;
      step();
      at_neg();
      rst_n = 1'b1;

      // single requester, release on an acked cycle
      rem[0] = 2;
      step(); at_neg();
      chk("s1_idle", arb_grant, 3'b000);
      step(); at_neg();
      chk("s1_grant", arb_grant, 3'b001);
      chk("s1_addr", bus.xram_addr, 16'h0100);
      chk("s1_ack", bus.req_ack, 3'b001);
      step(); at_neg();
      chk("s1_hold", arb_hold_cnt, 8'd1);
      step(); at_neg();
      chk("s1_rel_ack", bus.req_ack, 3'b001);
      chk("s1_rel_stb", bus.xram_stb, 1'b0);
      step(); at_neg();
      chk("s1_after", arb_grant, 3'b000);
      chk("s1_after_stb", bus.xram_stb, 1'b0);

      // all three at once: order 0,1,2 with one idle cycle between
      do_reset();
      for (int i = 0; i < N; i++) rem[i] = 2;
      step(); at_neg();
      chk("s2_idle", arb_grant, 3'b000);
      for (int c = 0; c < 12; c++) begin
         step(); at_neg();
         chk("s2_order", arb_grant, s2_exp[c]);
      end

      // lone owner at the hold limit keeps the grant
      do_reset();
      rem[2] = 9;
      step(); at_neg();
      step(); at_neg();
      chk("s4_grant", arb_grant, 3'b100);
      chk("s4_hold0", arb_hold_cnt, 8'd0);
      for (int k = 0; k < 9; k++) begin
         step(); at_neg();
         chk("s4_keep", arb_grant, 3'b100);
         chk("s4_hold", arb_hold_cnt, hold_exp[k]);
      end

      // preemption after MH acks when another requester waits
      do_reset();
      rem[0] = 10;
      step(); at_neg();
      a0 = 0;
      sw = 1'b0;
      for (int k = 0; k < 40 && !sw; k++) begin
         if (k == 1) rem[1] = 3;
         step(); at_neg();
         if (arb_grant == 3'b010) sw = 1'b1;
         else if (bus.req_ack[0]) a0++;
      end
      chk("pre_switch", sw, 1'b1);
      chk("pre_acks0", a0, 4);
      for (int k = 0; k < 100 && (rem[0] > 0 || rem[1] > 0); k++) step();
      chk("pre_done0", rem[0], 0);
      chk("pre_done1", rem[1], 0);

      // asynchronous reset in the high phase of clk during a grant
      rem[0] = 20;
      step(); at_neg();
      for (int k = 0; k < 20 && arb_grant != 3'b001; k++) begin
         step(); at_neg();
      end
      chk("ar_pre", arb_grant, 3'b001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_stb", bus.xram_stb, 1'b0);
      chk("ar_grant", arb_grant, 3'b000);
      chk("ar_ack", bus.req_ack, 3'b000);
      chk("ar_busy", arb_busy, 1'b0);
      for (int i = 0; i < N; i++) rem[i] = 2;
      step(); at_neg();
      rst_n = 1'b1;
      step(); at_neg();
      chk("ar_first", arb_grant, 3'b001);

      // randomized traffic with random ack timing
      do_reset();
      rand_en  = 1'b1;
      ack_rand = 1'b1;
      repeat (3000) step();
      rand_en = 1'b0;
      at_neg();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xram_arb.md
Name: xram_arb

Overview:
- Round-robin arbiter sharing the single XRAM byte port between the memory-mover unit (mem_wr) and the other XRAM-mastering accelerators behind the xiommu.
- Each requester drives its own stb/wr/addr/data. The arbiter grants exactly one owner, muxes that owner onto the XRAM bus, and routes xram_ack back to it.
- A burst-hold limit stops one long copy from starving the other requesters.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = mem_wr.
- ADDR_W, 16, XRAM address width.
- DATA_W, 8, XRAM data width.
- MAX_HOLD, 16, acked transfers after which the owner is preempted if another requester is waiting; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_stb  in  NUM_REQ  per-requester strobe, held high until the requester has finished with the bus.
- req_wr  in  NUM_REQ  per-requester write enable.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data_out  in  NUM_REQ*DATA_W  flattened write data, packed the same way.
- req_ack  out  NUM_REQ  per-requester acknowledge.
- req_data_in  out  DATA_W  read data, broadcast to all requesters.
- xram_addr  out  ADDR_W  to XRAM.
- xram_data_out  out  DATA_W  to XRAM.
- xram_data_in  in  DATA_W  from XRAM.
- xram_ack  in  1  from XRAM.
- xram_stb  out  1  to XRAM.
- xram_wr  out  1  to XRAM.
- arb_grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- arb_busy  out  1  high in GRANT.
- arb_hold_cnt  out  8  acked transfers by the current owner (verification visibility).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant=0, rr_ptr=0, hold_cnt=0.
  - All outputs 0 immediately.
  - A reset asserted mid-transfer drops xram_stb in the same cycle; the in-flight transfer is abandoned.
- States: IDLE, GRANT (2-bit encoding; the remaining codes go to IDLE).
- IDLE:
  - xram_stb=0, xram_wr=0, xram_addr=0, xram_data_out=0, req_ack=0.
  - If any req_stb is high, pick the first requester at or after rr_ptr in ascending modulo order. Next cycle: GRANT, grant=onehot(pick), hold_cnt=0.
  - Arbitration latency is one cycle from strobe to grant.
- GRANT (owner o), combinational outputs:
  - xram_stb=req_stb[o]; xram_wr=req_wr[o]; xram_addr, xram_data_out = owner's slices.
  - req_ack[o]=xram_ack; every other req_ack = 0.
  - req_data_in=xram_data_in at all times.
- GRANT, on each xram_ack: hold_cnt increments, saturating at 255.
- GRANT, release when req_stb[o]=0: next cycle IDLE, rr_ptr=(o+1) mod NUM_REQ. There is always one dead IDLE cycle between owners.
- GRANT, preemption: if xram_ack=1, hold_cnt+1 >= MAX_HOLD, and any other req_stb is high, then next cycle IDLE and rr_ptr=(o+1) mod NUM_REQ.
  - The preempted requester keeps its strobe high and simply sees no ack until it is re-granted.
  - Preemption only ever happens on an acked boundary, so no transfer is split.
- Hold limit with no other requester waiting: at the limit hold_cnt resets to 0 and the owner keeps the grant.
- xram_ack arriving in the same cycle the owner drops stb: the ack is forwarded and the release proceeds normally.
- xram_ack is ignored in IDLE.
- Requesters not granted are never acked, whatever their strobe state.
- Strobe changes on non-owners while in GRANT have no effect until the next IDLE.
- arb_busy = (state==GRANT).

Decomposition:
- Shared package xram_arb_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_GRANT=2'b01;
  - defaults for NUM_REQ, ADDR_W, DATA_W, MAX_HOLD;
  - requester index constants REQ_MEMWR=0, REQ_AES=1, REQ_SHA=2.
- One combinational sub-module, xram_arb_rr: inputs req vector and rr_ptr; outputs valid and a one-hot pick (rotate, priority-encode, rotate back).
- Muxing and the FSM stay in xram_arb.

Test Plan:
- Reset then a single requester: after rst_n rises, req_stb=3'b001, req_addr[0]=16'h0100, xram_ack every cycle -> arb_grant=001 one cycle later; xram_addr=16'h0100; req_ack[0] mirrors xram_ack; req_ack[2:1]=0.
- Simultaneous requests: req_stb=3'b111 from IDLE with rr_ptr=0 -> grant order 0,1,2, each owner releasing after 2 acks; exactly one IDLE cycle between owners; rr_ptr ends at 0.
- Preemption: MAX_HOLD=4, requester 0 holds stb for a 10-byte burst, requester 1 raises stb at cycle 2 -> requester 0 released right after its 4th ack; requester 1 granted after one IDLE cycle; requester 0 resumes after requester 1 drops stb and completes 6 more acks, for 10 in total.
- No contention at the limit: MAX_HOLD=4, only requester 2 active for 9 acks -> grant never leaves 100; hold_cnt sequence 1,2,3,0,1,2,3,0,1.
- Release on an acked cycle: owner drops stb in the same cycle as xram_ack -> req_ack pulses once; next cycle IDLE with xram_stb=0.
- Asynchronous reset mid-burst: rst_n low in the middle of a clk-high phase during GRANT -> xram_stb, arb_grant and req_ack go 0 without waiting for a clock edge; after release, requester 0 wins first.
